// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// State numbering is visible on the debug port and must stay fixed.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control: maps the FSM's ALUOp and the R-type Funct
// field onto the 3-bit ALU operation select.
module alu_decoder
    import mips_mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: state sequencing,
// Moore output decode and retired-instruction counter.
module mips_multicycle_ctrl
    import mips_mc_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             IorD,
    output logic             ALUSrcA,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSrc,
    output logic [2:0]       ALUControl,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             Branch,
    output logic             PCEn,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             IllegalOp,
    output logic [CNT_W-1:0] InstrCount,
    output logic [3:0]       State
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_reg;
    logic [CNT_W-1:0] count_reg;
    logic             mem_ready;

    logic       ir_write_c, pc_write_c, mem_write_c, reg_write_c;
    logic [1:0] alu_op;

    assign mem_ready = MEM_WAIT_EN ? MemReady : 1'b1;

    // Every path back to FETCH except the FETCH stall and the illegal-op
    // abort retires one instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_FETCH;
            count_reg <= '0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (mem_ready)
                        state_reg <= S_DECODE;
                end
                S_DECODE: begin
                    case (Op)
                        OP_LW, OP_SW: state_reg <= S_MEMADR;
                        OP_RTYPE:     state_reg <= S_EXECUTE;
                        OP_BEQ:       state_reg <= S_BRANCH;
                        OP_ADDI:      state_reg <= S_ADDIEX;
                        OP_J:         state_reg <= S_JUMP;
                        default:      state_reg <= S_FETCH;
                    endcase
                end
                S_MEMADR:
                    state_reg <= (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD: begin
                    if (mem_ready)
                        state_reg <= S_MEMWB;
                end
                S_MEMWRITE: begin
                    if (mem_ready) begin
                        state_reg <= S_FETCH;
                        count_reg <= count_reg + CNT_ONE;
                    end
                end
                S_EXECUTE: state_reg <= S_ALUWB;
                S_ADDIEX:  state_reg <= S_ADDIWB;
                S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
                    state_reg <= S_FETCH;
                    count_reg <= count_reg + CNT_ONE;
                end
                default: state_reg <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        IorD        = 1'b0;
        ALUSrcA     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcB     = 2'b00;
        PCSrc       = 2'b00;
        alu_op      = ALUOP_ADD;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        Branch      = 1'b0;
        IllegalOp   = 1'b0;
        case (state_reg)
            S_FETCH: begin
                ALUSrcB    = 2'b01;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB   = 2'b11;
                IllegalOp = !op_supported(Op);
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMREAD: IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg    = 1'b1;
                reg_write_c = 1'b1;
            end
            S_MEMWRITE: begin
                IorD        = 1'b1;
                mem_write_c = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst      = 1'b1;
                reg_write_c = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_SUB;
                PCSrc   = 2'b01;
                Branch  = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: reg_write_c = 1'b1;
            S_JUMP: begin
                PCSrc      = 2'b10;
                pc_write_c = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset masks the enables combinationally so a write in flight is
    // dropped in the same cycle reset rises.
    assign IRWrite  = ir_write_c  & ~reset;
    assign PCWrite  = pc_write_c  & ~reset;
    assign MemWrite = mem_write_c & ~reset;
    assign RegWrite = reg_write_c & ~reset;
    assign PCEn     = (pc_write_c | (Branch & Zero)) & ~reset;

    assign InstrCount = count_reg;
    assign State      = state_reg;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (Funct),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed-vector bench: the driver queues hand-computed expected outputs
// per cycle and a monitor compares them against the DUT at the falling edge.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  Op = 6'd0;
    logic [5:0]  Funct = 6'd0;
    logic        Zero = 1'b0;
    logic        MemReady = 1'b1;
    logic        IorD, ALUSrcA, RegDst, MemtoReg;
    logic [1:0]  ALUSrcB, PCSrc;
    logic [2:0]  ALUControl;
    logic        IRWrite, PCWrite, Branch, PCEn, MemWrite, RegWrite, IllegalOp;
    logic [31:0] InstrCount;
    logic [3:0]  State;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_WAIT_EN(1'b1), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .IorD(IorD), .ALUSrcA(ALUSrcA), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .ALUControl(ALUControl), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .Branch(Branch), .PCEn(PCEn), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IllegalOp(IllegalOp), .InstrCount(InstrCount), .State(State)
    );

    // sel = {IorD,ALUSrcA,RegDst,MemtoReg,Branch,PCSrc,ALUSrcB,ALUControl}
    localparam logic [11:0] X_FETCH  = 12'b0000_0_00_01_010;
    localparam logic [11:0] X_DECODE = 12'b0000_0_00_11_010;
    localparam logic [11:0] X_MEMADR = 12'b0100_0_00_10_010;
    localparam logic [11:0] X_MEMRD  = 12'b1000_0_00_00_010;
    localparam logic [11:0] X_MEMWB  = 12'b0001_0_00_00_010;
    localparam logic [11:0] X_MEMWR  = 12'b1000_0_00_00_010;
    localparam logic [11:0] X_EX_SLT = 12'b0100_0_00_00_111;
    localparam logic [11:0] X_EX_SUB = 12'b0100_0_00_00_110;
    localparam logic [11:0] X_ALUWB  = 12'b0010_0_00_00_010;
    localparam logic [11:0] X_BRANCH = 12'b0100_1_01_00_110;
    localparam logic [11:0] X_ADDIEX = 12'b0100_0_00_10_010;
    localparam logic [11:0] X_ADDIWB = 12'b0000_0_00_00_010;
    localparam logic [11:0] X_JUMP   = 12'b0000_0_10_00_010;

    // en = {IRWrite,PCWrite,PCEn,MemWrite,RegWrite,IllegalOp}
    localparam logic [5:0] E_NONE  = 6'b000000;
    localparam logic [5:0] E_FETCH = 6'b111000;
    localparam logic [5:0] E_RW    = 6'b000010;
    localparam logic [5:0] E_MW    = 6'b000100;
    localparam logic [5:0] E_PCEN  = 6'b001000;
    localparam logic [5:0] E_JUMP  = 6'b011000;
    localparam logic [5:0] E_ILL   = 6'b000001;

    typedef struct {
        string       nm;
        logic [3:0]  st;
        logic [5:0]  en;
        logic [11:0] sel;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   done = 1'b0;

    task automatic step(input string nm, input logic r, input logic [5:0] op,
                        input logic [5:0] fn, input logic z, input logic mr,
                        input logic [3:0] st, input logic [5:0] en,
                        input logic [11:0] sel, input logic [31:0] cnt);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; Op = op; Funct = fn; Zero = z; MemReady = mr;
        e.nm = nm; e.st = st; e.en = en; e.sel = sel; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic check(input string nm, input string what,
                         input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s %s: got 0x%0h expected 0x%0h at %0t", nm, what, got, want, $time);
        end
    endtask

    initial begin : monitor
        exp_t        e;
        logic [5:0]  en_a;
        logic [11:0] sel_a;
        while (!done) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                en_a  = {IRWrite, PCWrite, PCEn, MemWrite, RegWrite, IllegalOp};
                sel_a = {IorD, ALUSrcA, RegDst, MemtoReg, Branch, PCSrc, ALUSrcB, ALUControl};
                check(e.nm, "state", {28'd0, State}, {28'd0, e.st});
                check(e.nm, "enables", {26'd0, en_a}, {26'd0, e.en});
                check(e.nm, "selects", {20'd0, sel_a}, {20'd0, e.sel});
                check(e.nm, "count", InstrCount, e.cnt);
                $display("[TB] %-10s state=%0d en=%b sel=%b cnt=%0d", e.nm, State, en_a, sel_a, InstrCount);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : driver
        // reset holds FETCH with enables masked although MemReady=1
        step("reset0", 1, 6'b100011, 6'd0, 0, 1, 4'd0, E_NONE, X_FETCH, 0);
        step("reset1", 1, 6'b100011, 6'd0, 0, 1, 4'd0, E_NONE, X_FETCH, 0);
        // LW, no wait
        step("lw_f",   0, 6'b100011, 6'd0, 0, 1, 4'd0, E_FETCH, X_FETCH,  0);
        step("lw_d",   0, 6'b100011, 6'd0, 0, 1, 4'd1, E_NONE,  X_DECODE, 0);
        step("lw_a",   0, 6'b100011, 6'd0, 0, 1, 4'd2, E_NONE,  X_MEMADR, 0);
        step("lw_r",   0, 6'b100011, 6'd0, 0, 1, 4'd3, E_NONE,  X_MEMRD,  0);
        step("lw_wb",  0, 6'b100011, 6'd0, 0, 1, 4'd4, E_RW,    X_MEMWB,  0);
        // SW with one fetch stall and three write-wait cycles
        step("sw_fst", 0, 6'b101011, 6'd0, 0, 0, 4'd0, E_NONE,  X_FETCH,  1);
        step("sw_f",   0, 6'b101011, 6'd0, 0, 1, 4'd0, E_FETCH, X_FETCH,  1);
        step("sw_d",   0, 6'b101011, 6'd0, 0, 0, 4'd1, E_NONE,  X_DECODE, 1);
        step("sw_a",   0, 6'b101011, 6'd0, 0, 0, 4'd2, E_NONE,  X_MEMADR, 1);
        step("sw_w0",  0, 6'b101011, 6'd0, 0, 0, 4'd5, E_MW,    X_MEMWR,  1);
        step("sw_w1",  0, 6'b101011, 6'd0, 0, 0, 4'd5, E_MW,    X_MEMWR,  1);
        step("sw_w2",  0, 6'b101011, 6'd0, 0, 0, 4'd5, E_MW,    X_MEMWR,  1);
        step("sw_w3",  0, 6'b101011, 6'd0, 0, 1, 4'd5, E_MW,    X_MEMWR,  1);
        // BEQ taken, then not taken
        step("beq1_f", 0, 6'b000100, 6'd0, 1, 1, 4'd0, E_FETCH, X_FETCH,  2);
        step("beq1_d", 0, 6'b000100, 6'd0, 1, 1, 4'd1, E_NONE,  X_DECODE, 2);
        step("beq1_b", 0, 6'b000100, 6'd0, 1, 1, 4'd8, E_PCEN,  X_BRANCH, 2);
        step("beq0_f", 0, 6'b000100, 6'd0, 0, 1, 4'd0, E_FETCH, X_FETCH,  3);
        step("beq0_d", 0, 6'b000100, 6'd0, 0, 1, 4'd1, E_NONE,  X_DECODE, 3);
        step("beq0_b", 0, 6'b000100, 6'd0, 0, 1, 4'd8, E_NONE,  X_BRANCH, 3);
        // R-type slt and sub
        step("slt_f",  0, 6'b000000, 6'b101010, 0, 1, 4'd0, E_FETCH, X_FETCH,  4);
        step("slt_d",  0, 6'b000000, 6'b101010, 0, 1, 4'd1, E_NONE,  X_DECODE, 4);
        step("slt_e",  0, 6'b000000, 6'b101010, 0, 1, 4'd6, E_NONE,  X_EX_SLT, 4);
        step("slt_wb", 0, 6'b000000, 6'b101010, 0, 1, 4'd7, E_RW,    X_ALUWB,  4);
        step("sub_f",  0, 6'b000000, 6'b100010, 0, 1, 4'd0, E_FETCH, X_FETCH,  5);
        step("sub_d",  0, 6'b000000, 6'b100010, 0, 1, 4'd1, E_NONE,  X_DECODE, 5);
        step("sub_e",  0, 6'b000000, 6'b100010, 0, 1, 4'd6, E_NONE,  X_EX_SUB, 5);
        step("sub_wb", 0, 6'b000000, 6'b100010, 0, 1, 4'd7, E_RW,    X_ALUWB,  5);
        // ADDI
        step("addi_f", 0, 6'b001000, 6'd0, 0, 1, 4'd0,  E_FETCH, X_FETCH,  6);
        step("addi_d", 0, 6'b001000, 6'd0, 0, 1, 4'd1,  E_NONE,  X_DECODE, 6);
        step("addi_e", 0, 6'b001000, 6'd0, 0, 1, 4'd9,  E_NONE,  X_ADDIEX, 6);
        step("addi_w", 0, 6'b001000, 6'd0, 0, 1, 4'd10, E_RW,    X_ADDIWB, 6);
        // J
        step("j_f",    0, 6'b000010, 6'd0, 0, 1, 4'd0,  E_FETCH, X_FETCH,  7);
        step("j_d",    0, 6'b000010, 6'd0, 0, 1, 4'd1,  E_NONE,  X_DECODE, 7);
        step("j_j",    0, 6'b000010, 6'd0, 0, 1, 4'd11, E_JUMP,  X_JUMP,   7);
        // illegal opcode: pulse in DECODE, no retire
        step("ill_f",  0, 6'b111111, 6'd0, 0, 1, 4'd0, E_FETCH, X_FETCH,  8);
        step("ill_d",  0, 6'b111111, 6'd0, 0, 1, 4'd1, E_ILL,   X_DECODE, 8);
        step("ill_f2", 0, 6'b100011, 6'd0, 0, 1, 4'd0, E_FETCH, X_FETCH,  8);
        // LW aborted by reset while waiting in MEMREAD
        step("rlw_d",  0, 6'b100011, 6'd0, 0, 1, 4'd1, E_NONE,  X_DECODE, 8);
        step("rlw_a",  0, 6'b100011, 6'd0, 0, 0, 4'd2, E_NONE,  X_MEMADR, 8);
        step("rlw_r",  0, 6'b100011, 6'd0, 0, 0, 4'd3, E_NONE,  X_MEMRD,  8);
        step("rlw_rst",1, 6'b100011, 6'd0, 0, 1, 4'd0, E_NONE,  X_FETCH,  0);
        step("rlw_f",  0, 6'b100011, 6'd0, 0, 1, 4'd0, E_FETCH, X_FETCH,  0);
        step("rlw_d2", 0, 6'b100011, 6'd0, 0, 1, 4'd1, E_NONE,  X_DECODE, 0);
        @(negedge clk);
        @(negedge clk);
        done = 1'b1;
        check("drain", "queue", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
